// File: rtl/tech_sync_handshake_tx.sv
// Source end of a two-phase toggle handshake that carries a WIDTH-bit word from clk to another domain.
// Define TECH_SYNC_HANDSHAKE_TX_SKID_EN to add a one-entry holding buffer that accepts a word while busy.
`timescale 1ns/1ps
module tech_sync_handshake_tx #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clk__enable,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             cdc_req,
  output logic [WIDTH-1:0] cdc_data,
  input  logic             cdc_ack,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  logic   ack_s1;
  logic   ack_s;
  state_t state;
  logic   accept;

  // cdc_ack lands directly in the first flop; nothing combinational may sit in front of it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_s1 <= 1'b0;
      ack_s  <= 1'b0;
    end else if (clk__enable) begin
      ack_s1 <= cdc_ack;
      ack_s  <= ack_s1;
    end
  end

  // State is never stored: it is always recomputed from the request/ack pair, so a stray ack cannot wedge it.
  assign state  = (cdc_req == ack_s) ? IDLE : BUSY;
  assign busy   = (state == BUSY);
  assign accept = clk__enable & data_valid & data_ready;

`ifdef TECH_SYNC_HANDSHAKE_TX_SKID_EN
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;

  assign data_ready = ~hold_valid;

  // A held word always launches first; while it is held data_ready is low, so no newer word can overtake it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cdc_req    <= 1'b0;
      cdc_data   <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
    end else if (clk__enable) begin
      if (state == IDLE && hold_valid) begin
        cdc_data   <= hold_data;
        cdc_req    <= ~cdc_req;
        hold_valid <= 1'b0;
      end else if (accept) begin
        if (state == IDLE) begin
          cdc_data <= data_in;
          cdc_req  <= ~cdc_req;
        end else begin
          hold_data  <= data_in;
          hold_valid <= 1'b1;
        end
      end
    end
  end
`else
  assign data_ready = (state == IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cdc_req  <= 1'b0;
      cdc_data <= '0;
    end else if (accept) begin
      cdc_data <= data_in;
      cdc_req  <= ~cdc_req;
    end
  end
`endif

endmodule

// File: tb/tb_tech_sync_handshake_tx.sv
// Randomized scoreboard bench for tech_sync_handshake_tx with a behavioural destination-domain model.
// Build with TECH_SYNC_HANDSHAKE_TX_SKID_EN to also exercise the holding buffer.
`timescale 1ns/1ps
module tb_tech_sync_handshake_tx;

`ifdef TECH_SYNC_HANDSHAKE_TX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk;
  logic        clk_enable;
  logic        reset_n;
  logic [31:0] data_in;
  logic        data_valid;
  logic        data_ready;
  logic        cdc_req;
  logic [31:0] cdc_data;
  logic        cdc_ack;
  logic        busy;

  int total = 0;
  int bad = 0;
  int toggle_count = 0;
  logic [31:0] expq[$];

  logic        ack_auto;
  logic        ack_manual;
  int          ack_delay = -1;
  logic        last_req;
  logic [31:0] captured;

  tech_sync_handshake_tx #(.WIDTH(32)) dut (
    .clk(clk),
    .clk__enable(clk_enable),
    .reset_n(reset_n),
    .data_in(data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .cdc_req(cdc_req),
    .cdc_data(cdc_data),
    .cdc_ack(cdc_ack),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present one word and wait until the DUT takes it; the word is queued as the next expected capture.
  task automatic applyStimulus(input logic [31:0] w);
    int n;
    n = 0;
    @(negedge clk);
    data_in = w;
    data_valid = 1'b1;
    while (!(data_ready && clk_enable) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout: word 0x%08h never accepted", w);
    end else begin
      expq.push_back(w);
    end
    @(posedge clk);
    #1 data_valid = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while ((expq.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("[TB] FAIL drain_timeout: queue=%0d busy=%0b, expected empty and idle", expq.size(), busy);
    end
  endtask

  // Destination model: acknowledges each pending request after a random delay, or follows ack_manual.
  always @(negedge clk) begin
    if (!reset_n) begin
      cdc_ack = 1'b0;
      ack_delay = -1;
    end else if (ack_auto) begin
      if (cdc_ack != cdc_req) begin
        if (ack_delay < 0) ack_delay = $urandom_range(0, 10);
        if (ack_delay == 0) begin
          cdc_ack = cdc_req;
          ack_delay = -1;
        end else begin
          ack_delay--;
        end
      end
    end else begin
      cdc_ack = ack_manual;
    end
  end

  // Monitor: every request toggle is a capture compared against the scoreboard; data must hold while busy.
  always @(negedge clk) begin
    if (!reset_n) begin
      last_req = 1'b0;
    end else if (cdc_req != last_req) begin
      last_req = cdc_req;
      toggle_count++;
      captured = cdc_data;
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL capture_unexpected: got 0x%08h, expected no transfer", cdc_data);
      end else begin
        checkOutput("capture", cdc_data, expq.pop_front());
      end
    end else if (busy) begin
      checkOutput("data_stable", cdc_data, captured);
    end
  end

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0;
    reset_n = 1'b0;
    clk_enable = 1'b1;
    data_in = '0;
    data_valid = 1'b0;
    ack_auto = 1'b0;
    ack_manual = 1'b0;
    last_req = 1'b0;
    captured = '0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Reset state after idling.
    repeat (5) @(negedge clk);
    checkOutput("reset_ready", {31'd0, data_ready}, 32'd1);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_req", {31'd0, cdc_req}, 32'd0);
    checkOutput("reset_data", cdc_data, 32'd0);

    // Single word with a hand-driven acknowledge.
    applyStimulus(32'hDEADBEEF);
    checkOutput("launch_req", {31'd0, cdc_req}, 32'd1);
    checkOutput("launch_data", cdc_data, 32'hDEADBEEF);
    repeat (3) begin
      @(negedge clk);
      checkOutput("ready_while_busy", {31'd0, data_ready}, {31'd0, SKID});
      checkOutput("busy_high", {31'd0, busy}, 32'd1);
    end
    #1 ack_manual = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("ready_after_1_edge", {31'd0, data_ready}, {31'd0, SKID});
    checkOutput("busy_after_1_edge", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("ready_after_2_edges", {31'd0, data_ready}, 32'd1);
    checkOutput("busy_after_2_edges", {31'd0, busy}, 32'd0);

    // Clock enable low freezes the synchronizer while the ack toggles.
    applyStimulus(32'h12345678);
    repeat (3) @(negedge clk);
    #1;
    clk_enable = 1'b0;
    ack_manual = 1'b0;
    repeat (4) begin
      @(negedge clk);
      checkOutput("frozen_busy", {31'd0, busy}, 32'd1);
      checkOutput("frozen_ready", {31'd0, data_ready}, {31'd0, SKID});
    end
    #1 clk_enable = 1'b1;
    @(negedge clk);
    checkOutput("thaw_busy_1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    checkOutput("thaw_busy_2", {31'd0, busy}, 32'd0);
    checkOutput("thaw_ready", {31'd0, data_ready}, 32'd1);

    // Asynchronous reset mid-transfer abandons the word.
    applyStimulus(32'hA5A5A5A5);
    @(negedge clk);
    checkOutput("pre_reset_busy", {31'd0, busy}, 32'd1);
    checkOutput("pre_reset_data", cdc_data, 32'hA5A5A5A5);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_req", {31'd0, cdc_req}, 32'd0);
    checkOutput("async_reset_data", cdc_data, 32'd0);
    checkOutput("async_reset_busy", {31'd0, busy}, 32'd0);
    ack_manual = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready", {31'd0, data_ready}, 32'd1);
    checkOutput("post_reset_busy", {31'd0, busy}, 32'd0);

    // Back-to-back words with random acknowledge delays.
    ack_auto = 1'b1;
    t0 = toggle_count;
    for (int i = 1; i <= 4; i++) applyStimulus(32'(i));
    waitIdle(400);
    checkOutput("toggle_count_4", 32'(toggle_count - t0), 32'd4);

    // Random words with random gaps.
    t0 = toggle_count;
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      applyStimulus($urandom);
    end
    waitIdle(2000);
    checkOutput("toggle_count_20", 32'(toggle_count - t0), 32'd20);

`ifdef TECH_SYNC_HANDSHAKE_TX_SKID_EN
    // Holding buffer: second word parks while busy, third is held off until the buffer drains.
    ack_auto = 1'b0;
    ack_manual = cdc_ack;
    applyStimulus(32'h11);
    applyStimulus(32'h22);
    checkOutput("skid_ready_low", {31'd0, data_ready}, 32'd0);
    checkOutput("skid_data_11", cdc_data, 32'h11);
    data_in = 32'h33;
    data_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("skid_holdoff", {31'd0, data_ready}, 32'd0);
    end
    #1 ack_manual = ~ack_manual;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    checkOutput("skid_idle_edge_busy", {31'd0, busy}, 32'd0);
    checkOutput("skid_idle_edge_data", cdc_data, 32'h11);
    @(negedge clk);
    checkOutput("skid_launch_22", cdc_data, 32'h22);
    checkOutput("skid_ready_back", {31'd0, data_ready}, 32'd1);
    expq.push_back(32'h33);
    @(posedge clk);
    #1 data_valid = 1'b0;
    checkOutput("skid_33_held", cdc_data, 32'h22);
    checkOutput("skid_33_ready_low", {31'd0, data_ready}, 32'd0);
    ack_auto = 1'b1;
    waitIdle(400);
`endif

    checkOutput("queue_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
